// File: rtl/uni_shift_ctrl.sv
// Command sequencer for a 4-mode universal shift register: load a word, shift it
// N places left or right (fill or rotate), then pulse done.
module uni_shift_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             cmd_dir,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] sr_out,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_sin_right,
  output logic             sr_sin_left,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] in_d;
  logic             busy_d, done_d;
  logic [CNT_W-1:0] rem_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             fill_q, fill_d;
  logic [1:0]       shift_sel;

  assign shift_sel = dir_q ? SEL_LEFT : SEL_RIGHT;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      sr_select <= SEL_HOLD;
      sr_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
      fill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_select <= sel_d;
      sr_in     <= in_d;
      busy      <= busy_d;
      done      <= done_d;
      remaining <= rem_d;
      dir_q     <= dir_d;
      rot_q     <= rot_d;
      fill_q    <= fill_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    sel_d   = SEL_HOLD;
    in_d    = sr_in;
    busy_d  = busy;
    done_d  = 1'b0;
    rem_d   = remaining;
    dir_d   = dir_q;
    rot_d   = rot_q;
    fill_d  = fill_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        rem_d  = '0;
        if (start) begin
          state_d = S_LOAD;
          sel_d   = SEL_LOAD;
          in_d    = cmd_data;
          busy_d  = 1'b1;
          rem_d   = cmd_count;
          dir_d   = cmd_dir;
          rot_d   = cmd_rot;
          fill_d  = cmd_fill;
        end
      end
      S_LOAD: begin
        busy_d = 1'b1;
        if (remaining != '0) begin
          state_d = S_SHIFT;
          sel_d   = shift_sel;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        rem_d  = remaining - CNT_ONE;
        if (remaining == CNT_ONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          sel_d = shift_sel;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        rem_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        rem_d   = '0;
      end
    endcase
  end

  // Serial inputs stay combinational so a rotate samples the register's current end bit
  always_comb begin
    sr_sin_right = fill_q;
    sr_sin_left  = fill_q;
    if (rot_q) begin
      sr_sin_right = (sr_out & LSB_MASK) != '0;
      sr_sin_left  = (sr_out & MSB_MASK) != '0;
    end
  end

endmodule

// File: tb/tb_uni_shift_ctrl.sv
// Scoreboard bench for uni_shift_ctrl driving a behavioural universal shift register.
module tb_uni_shift_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             clear;
  logic             start;
  logic             cmd_dir;
  logic             cmd_rot;
  logic             cmd_fill;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] sr_out;
  logic [1:0]       sr_select;
  logic [WIDTH-1:0] sr_in;
  logic             sr_sin_right;
  logic             sr_sin_left;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  logic [WIDTH-1:0] q = '0;
  assign sr_out = q;

  uni_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .cmd_dir      (cmd_dir),
    .cmd_rot      (cmd_rot),
    .cmd_fill     (cmd_fill),
    .cmd_count    (cmd_count),
    .cmd_data     (cmd_data),
    .sr_out       (sr_out),
    .sr_select    (sr_select),
    .sr_in        (sr_in),
    .sr_sin_right (sr_sin_right),
    .sr_sin_left  (sr_sin_left),
    .busy         (busy),
    .done         (done),
    .remaining    (remaining)
  );

  always #5 clk = ~clk;

  // Controlled universal shift register
  always @(posedge clk) begin
    case (sr_select)
      2'b01:   q <= {sr_sin_right, q[WIDTH-1:1]};
      2'b10:   q <= {q[WIDTH-2:0], sr_sin_left};
      2'b11:   q <= sr_in;
      default: q <= q;
    endcase
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic busy_prev = 1'b0;

  typedef struct {
    int q;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected final word: apply count single-place shifts with integer arithmetic
  function automatic int ref_result(input int data, input bit dir, input bit rot,
                                    input bit fill, input int count);
    int v;
    int sin;
    int top;
    int modv;
    top  = 1 << (WIDTH - 1);
    modv = 1 << WIDTH;
    v    = data;
    for (int i = 0; i < count; i++) begin
      if (!dir) begin
        sin = rot ? (v % 2) : int'(fill);
        v   = (v / 2) + sin * top;
      end else begin
        sin = rot ? (v / top) : int'(fill);
        v   = ((v * 2) % modv) + sin;
      end
    end
    return v;
  endfunction

  // Monitor: every done pulse retires the oldest expected command
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) rise_cyc = cyc;
    busy_prev = busy;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result_q", 32'(q), 32'(mon_e.q));
        check("done_latency", 32'(cyc - rise_cyc), 32'(mon_e.cnt + 1));
      end
    end
  end

  task automatic scramble_cmd();
    cmd_data  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    cmd_dir   = 1'($urandom_range(0, 1));
    cmd_rot   = 1'($urandom_range(0, 1));
    cmd_fill  = 1'($urandom_range(0, 1));
    cmd_count = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
  endtask

  // Wait for idle, present one command for one edge, return at the LOAD-cycle negedge
  task automatic issue(input int data, input bit dir, input bit rot, input bit fill,
                       input int count, input bit expect_done);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b expected 0 within 100 cycles", busy);
    end
    cmd_data  = WIDTH'(data);
    cmd_dir   = dir;
    cmd_rot   = rot;
    cmd_fill  = fill;
    cmd_count = CNT_W'(count);
    start     = 1'b1;
    if (expect_done) begin
      e.q   = ref_result(data, dir, rot, fill, count);
      e.cnt = count;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble_cmd();
  endtask

  int exp_sel[4] = '{3, 1, 1, 0};
  int exp_rem[4] = '{2, 2, 1, 0};

  initial begin
    exp_t e;
    clear = 1'b1;
    start = 1'b1;
    scramble_cmd();

    // Reset, with start asserted underneath it
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("reset_sel", 32'(sr_select), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_remaining", 32'(remaining), 32'(0));
    check("reset_sr_in", 32'(sr_in), 32'(0));
    clear = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", 32'(busy), 32'(0));

    // Right shift with zero fill, select/remaining traced per cycle
    issue(4'b1101, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("t2_sel", 32'(sr_select), 32'(exp_sel[k]));
      check("t2_remaining", 32'(remaining), 32'(exp_rem[k]));
      check("t2_busy", 32'(busy), 32'(1));
    end

    // Left rotate
    issue(4'b1101, 1'b1, 1'b1, 1'b0, 3, 1'b1);

    // Zero count: LOAD straight to DONE
    issue(4'b1101, 1'b0, 1'b1, 1'b1, 0, 1'b1);

    // start held through a whole command; second accept right after DONE
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    cmd_data  = 4'b1001;
    cmd_dir   = 1'b0;
    cmd_rot   = 1'b1;
    cmd_fill  = 1'b0;
    cmd_count = CNT_W'(1);
    start     = 1'b1;
    e.q = ref_result(4'b1001, 1'b0, 1'b1, 1'b0, 1);
    e.cnt = 1;
    sb.push_back(e);
    e.q = ref_result(4'b0110, 1'b0, 1'b1, 1'b0, 1);
    e.cnt = 1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_data = 4'b0110;
    repeat (4) @(negedge clk);
    start = 1'b0;

    // clear in the third SHIFT cycle aborts without a done pulse
    issue(0, 1'b1, 1'b0, 1'b1, 6, 1'b0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_q", 32'(q), 32'(4'b0111));
    check("abort_sel", 32'(sr_select), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_remaining", 32'(remaining), 32'(0));
    repeat (3) @(negedge clk);
    check("abort_q_held", 32'(q), 32'(4'b0111));

    // Same command to completion
    issue(0, 1'b1, 1'b0, 1'b1, 6, 1'b1);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << CNT_W) - 1)), 1'b1);
    end

    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
